// File: rtl/multi_timer.sv
// Multi-channel ms timer on the abus/dbus I/O bus with an OR-combined IRQ.
// Define TIMER_PRESCALE_EN to add a per-channel 4-bit tick divider (CTL[19:16]).
module multi_timer #(
  parameter int          DBITS        = 32,
  parameter int          NCH          = 4,
  parameter int          TICKS_PER_MS = 10000,
  parameter logic [31:0] BASE_ADDR    = 32'hF0000200,
  parameter logic [31:0] STAT_ADDR    = 32'hF0000300
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [DBITS-1:0] abus,
  inout  wire  [DBITS-1:0] dbus,
  input  logic             we,
  output logic             intr
);

  localparam int               PW   = $clog2(TICKS_PER_MS);
  localparam logic [PW-1:0]    PMAX = PW'(TICKS_PER_MS - 1);
  localparam logic [DBITS-1:0] ONE  = DBITS'(1);
  localparam logic [DBITS-1:0] BA   = DBITS'(BASE_ADDR);
  localparam logic [DBITS-1:0] SA   = DBITS'(STAT_ADDR);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [DBITS-1:0] cnt_q [NCH];
  logic [DBITS-1:0] cnt_d [NCH];
  logic [DBITS-1:0] lim_q [NCH];
  logic [DBITS-1:0] lim_d [NCH];
  logic [DBITS-1:0] ctl_val [NCH];

  logic [NCH-1:0] rdy_q, rdy_d, ovr_q, ovr_d;
  logic [NCH-1:0] en_q, en_d, os_q, os_d;
  logic [NCH-1:0] ie_q, ie_d;
  logic [NCH-1:0] rdy_k, ovr_k;

  logic [NCH-1:0] sel_cnt, sel_lim, sel_ctl;
  logic [NCH-1:0] wr_cnt, wr_lim, wr_ctl;
  logic [NCH-1:0] adv, term, div_hit;
  logic           sel_stat;

  logic [DBITS-1:0] wdat;
  logic [DBITS-1:0] rd_data;
  logic             rd_en;

  assign wdat = dbus;
  assign dbus = rd_en ? rd_data : {DBITS{1'bz}};
  assign intr = |(rdy_q & ie_q);

  always_comb begin
    tick  = (pre_q == PMAX);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_comb begin
    sel_cnt  = '0;
    sel_lim  = '0;
    sel_ctl  = '0;
    sel_stat = (abus == SA);
    for (int i = 0; i < NCH; i++) begin
      sel_cnt[i] = (abus == BA + DBITS'(16*i));
      sel_lim[i] = (abus == BA + DBITS'(16*i + 4));
      sel_ctl[i] = (abus == BA + DBITS'(16*i + 8));
    end
    wr_cnt = {NCH{we}} & sel_cnt;
    wr_lim = {NCH{we}} & sel_lim;
    wr_ctl = {NCH{we}} & sel_ctl;
  end

`ifdef TIMER_PRESCALE_EN
  logic [3:0] psc_q [NCH];
  logic [3:0] psc_d [NCH];
  logic [3:0] div_q [NCH];
  logic [3:0] div_d [NCH];

  always_comb begin
    div_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      div_hit[i] = (div_q[i] == psc_q[i]);
      psc_d[i]   = wr_ctl[i] ? wdat[19:16] : psc_q[i];
      div_d[i]   = div_q[i];
      // restart the divider on enable or a new prescale value
      if (wr_ctl[i] || (en_d[i] && !en_q[i]))
        div_d[i] = '0;
      else if (tick && en_q[i])
        div_d[i] = div_hit[i] ? 4'd0 : div_q[i] + 4'd1;
    end
  end
`else
  assign div_hit = '1;
`endif

  always_comb begin
    adv   = '0;
    term  = '0;
    rdy_k = '0;
    ovr_k = '0;
    for (int i = 0; i < NCH; i++) begin
      adv[i]   = tick & en_q[i] & div_hit[i];
      term[i]  = adv[i] & ~wr_cnt[i] & (lim_q[i] != '0) &
                 (cnt_q[i] == lim_q[i] - ONE);
      // software clears land before a same-cycle terminal event
      rdy_k[i] = rdy_q[i] & ~(wr_ctl[i] & ~wdat[0]);
      ovr_k[i] = ovr_q[i] & ~(wr_ctl[i] & ~wdat[2]);
    end
  end

  always_comb begin
    rdy_d = rdy_k | term;
    ovr_d = ovr_k;
    en_d  = en_q;
    os_d  = os_q;
    ie_d  = ie_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      lim_d[i] = wr_lim[i] ? wdat : lim_q[i];
      if (wr_cnt[i])
        cnt_d[i] = wdat;
      else if (term[i])
        cnt_d[i] = '0;
      else if (adv[i])
        cnt_d[i] = cnt_q[i] + ONE;
      if (term[i])
        ovr_d[i] = rdy_k[i] | ovr_k[i];
      if (wr_ctl[i]) begin
        en_d[i] = wdat[4];
        os_d[i] = wdat[5];
        ie_d[i] = wdat[8];
      end
      if (term[i] && os_q[i])
        en_d[i] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctl_val[i]    = '0;
      ctl_val[i][0] = rdy_q[i];
      ctl_val[i][2] = ovr_q[i];
      ctl_val[i][4] = en_q[i];
      ctl_val[i][5] = os_q[i];
      ctl_val[i][8] = ie_q[i];
`ifdef TIMER_PRESCALE_EN
      ctl_val[i][19:16] = psc_q[i];
`endif
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_data = '0;
    if (!we) begin
      if (sel_stat) begin
        rd_en            = 1'b1;
        rd_data[NCH-1:0] = rdy_q;
      end
      for (int i = 0; i < NCH; i++) begin
        if (sel_cnt[i]) begin
          rd_en   = 1'b1;
          rd_data = cnt_q[i];
        end
        if (sel_lim[i]) begin
          rd_en   = 1'b1;
          rd_data = lim_q[i];
        end
        if (sel_ctl[i]) begin
          rd_en   = 1'b1;
          rd_data = ctl_val[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      pre_q <= '0;
      rdy_q <= '0;
      ovr_q <= '0;
      en_q  <= '0;
      os_q  <= '0;
      ie_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        lim_q[i] <= '0;
`ifdef TIMER_PRESCALE_EN
        psc_q[i] <= '0;
        div_q[i] <= '0;
`endif
      end
    end else begin
      pre_q <= pre_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      en_q  <= en_d;
      os_q  <= os_d;
      ie_q  <= ie_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        lim_q[i] <= lim_d[i];
`ifdef TIMER_PRESCALE_EN
        psc_q[i] <= psc_d[i];
        div_q[i] <= div_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: 4 channels, 4 clocks per ms tick.
// Bus is pulled up so an undriven (Z) read shows as all ones.
module tb_multi_timer;

  localparam int          T = 4;
  localparam int          N = 4;
  localparam logic [31:0] B = 32'hF0000200;
  localparam logic [31:0] S = 32'hF0000300;

  logic        clk    = 1'b0;
  logic        init_n = 1'b0;
  logic        we     = 1'b0;
  logic [31:0] abus   = 32'h0;
  logic [31:0] drv    = 32'h0;
  logic        drv_en = 1'b0;
  wire  [31:0] dbus;
  logic        intr;

  int checks = 0;
  int errors = 0;
  int pc;

  assign dbus = drv_en ? drv : 'z;
  pullup (dbus);

  multi_timer #(
    .DBITS(32),
    .NCH(N),
    .TICKS_PER_MS(T)
  ) dut (
    .clk(clk),
    .init_n(init_n),
    .abus(abus),
    .dbus(dbus),
    .we(we),
    .intr(intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge init_n)
    if (!init_n) pc <= 0;
    else         pc <= (pc == T-1) ? 0 : pc + 1;

  function automatic logic [31:0] ra(int ch, int r);
    return B + 32'(16*ch) + 32'(4*r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    abus = a;
    we   = 1'b0;
    #1;
    chk(tag, dbus, exp);
  endtask

  task automatic wr_raw(input logic [31:0] a, input logic [31:0] d);
    abus   = a;
    drv    = d;
    drv_en = 1'b1;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_raw(a, d);
  endtask

  task automatic wait_pre;
    int n = 0;
    while (pc != T-1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) chk("tick_timeout", 32'(n), 32'(T-1));
  endtask

  task automatic wr_tick(input logic [31:0] a, input logic [31:0] d);
    wait_pre();
    wr_raw(a, d);
  endtask

  task automatic step_tick(input int k);
    for (int j = 0; j < k; j++) begin
      wait_pre();
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #2;
    rd_chk("rst_cnt0", ra(0, 0), 32'h0);
    rd_chk("rst_ctl0", ra(0, 2), 32'h0);
    chk("rst_intr", 32'(intr), 32'h0);
    #10 init_n = 1'b1;

    // get ch0 running with READY set, then reset mid-count
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 2), 32'h110);
    step_tick(4);
    rd_chk("pre_cnt0", ra(0, 0), 32'd1);
    chk("pre_intr", 32'(intr), 32'h1);
    #1 init_n = 1'b0;
    #1;
    chk("ares_intr", 32'(intr), 32'h0);
    rd_chk("ares_cnt0", ra(0, 0), 32'h0);
    rd_chk("ares_lim0", ra(0, 1), 32'h0);
    rd_chk("ares_ctl0", ra(0, 2), 32'h0);
    @(negedge clk);
    #1 init_n = 1'b1;

    wr(ra(2, 1), 32'd5);
    rd_chk("lim2_rb", ra(2, 1), 32'd5);
    rd_chk("unmap_c", ra(2, 3), 32'hFFFF_FFFF);
    rd_chk("unmap_s", S + 32'd4, 32'hFFFF_FFFF);
    rd_chk("stat_0", S, 32'h0);

    // periodic channel with interrupt
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 2), 32'h110);
    rd_chk("per_c0", ra(0, 0), 32'd0);
    step_tick(1);
    rd_chk("per_c1", ra(0, 0), 32'd1);
    step_tick(1);
    rd_chk("per_c2", ra(0, 0), 32'd2);
    chk("per_nointr", 32'(intr), 32'h0);
    step_tick(1);
    rd_chk("per_c3", ra(0, 0), 32'd0);
    rd_chk("per_ctl", ra(0, 2), 32'h111);
    chk("per_intr", 32'(intr), 32'h1);
    wr(ra(0, 2), 32'h110);
    chk("clr_intr", 32'(intr), 32'h0);
    rd_chk("clr_ctl", ra(0, 2), 32'h110);
    wr(ra(0, 2), 32'h0);

    // overrun after two unacknowledged periods
    wr(ra(1, 1), 32'd2);
    wr(ra(1, 2), 32'h010);
    step_tick(4);
    rd_chk("ovr_ctl", ra(1, 2), 32'h015);
    rd_chk("ovr_stat", S, 32'h2);
    chk("ovr_noie", 32'(intr), 32'h0);
    wr(ra(1, 2), 32'h010);
    rd_chk("ovr_clr", ra(1, 2), 32'h010);
    wr(ra(1, 2), 32'h0);

    // one-shot
    wr(ra(3, 1), 32'd2);
    wr(ra(3, 2), 32'h130);
    step_tick(1);
    rd_chk("os_c1", ra(3, 0), 32'd1);
    step_tick(1);
    rd_chk("os_ctl", ra(3, 2), 32'h121);
    rd_chk("os_cnt", ra(3, 0), 32'd0);
    rd_chk("os_stat", S, 32'h8);
    chk("os_intr", 32'(intr), 32'h1);
    step_tick(10);
    rd_chk("os_hold", ra(3, 0), 32'd0);
    rd_chk("os_ctl2", ra(3, 2), 32'h121);
    wr(ra(3, 2), 32'h0);
    chk("os_clr", 32'(intr), 32'h0);

    // READY clear on the same edge as a terminal event
    wr(ra(2, 1), 32'd2);
    wr(ra(2, 2), 32'h010);
    step_tick(2);
    rd_chk("col_rdy", ra(2, 2), 32'h011);
    step_tick(1);
    rd_chk("col_c1", ra(2, 0), 32'd1);
    wr_tick(ra(2, 2), 32'h010);
    rd_chk("col_ctl", ra(2, 2), 32'h011);
    rd_chk("col_cnt", ra(2, 0), 32'd0);

    // CNT write on a terminal tick: write wins, no event
    wr(ra(2, 2), 32'h010);
    rd_chk("cw_clr", ra(2, 2), 32'h010);
    step_tick(1);
    wr_tick(ra(2, 0), 32'd7);
    rd_chk("cw_cnt", ra(2, 0), 32'd7);
    rd_chk("cw_ctl", ra(2, 2), 32'h010);
    wr(ra(2, 2), 32'h0);

    wr(ra(0, 2), 32'hF0000);
`ifdef TIMER_PRESCALE_EN
    rd_chk("psc_rb", ra(0, 2), 32'hF0000);
    wr(ra(0, 1), 32'd2);
    wr(ra(0, 2), 32'h20010);
    step_tick(5);
    rd_chk("psc_5", ra(0, 2), 32'h20010);
    step_tick(1);
    rd_chk("psc_6", ra(0, 2), 32'h20011);
`else
    rd_chk("psc_rb", ra(0, 2), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
